// File: rtl/wb_dma_copy_pkg.sv
// wb_dma_copy shared definitions:
// register offsets, CTRL bit positions, FSM states.
package wb_dma_copy_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IE    = 3;
  localparam int CTRL_ERR   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    GAP_W,
    WR,
    GAP_R,
    FIN
  } state_e;

endpackage

// File: rtl/wb_dma_copy_if.sv
// Classic Wishbone bus bundle used for both the
// register (slave) port and the copy (master) port.
interface wb_dma_copy_if #(
  parameter int AW = 32
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic          ack;
  logic          err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_dma_copy_regs.sv
// Register port of the copy engine: decode, one-cycle
// ack, SRC/DST/LEN/CTRL storage and the interrupt flop.
module wb_dma_regs
  import wb_dma_copy_pkg::*;
#(
  parameter int AW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  wb_dma_copy_if.slave     s,
  input  logic             busy_i,
  input  logic             done_set_i,
  input  logic             err_set_i,
  output logic             start_o,
  output logic [AW-1:0]    src_o,
  output logic [AW-1:0]    dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             irq_o
);

  logic             ack_q, ack_d;
  logic [31:0]      rdat_q, rdat_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ie_q, ie_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             irq_q, irq_d;
  logic             req, wr, wr_ctrl, start;
  logic [1:0]       a;
  logic             unused_ok;

  assign unused_ok = ^{s.sel, s.adr[AW-1:4], s.adr[1:0]};

  always_comb begin
    req     = s.cyc & s.stb & ~ack_q;
    wr      = req & s.we;
    a       = s.adr[3:2];
    wr_ctrl = wr & (a == REG_CTRL);
    start   = wr_ctrl & s.dat_w[CTRL_START] & ~busy_i;
    ack_d   = req;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ie_d    = ie_q;
    done_d  = done_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    if (wr && !busy_i) begin
      case (a)
        REG_SRC: src_d = AW'(s.dat_w);
        REG_DST: dst_d = AW'(s.dat_w);
        REG_LEN: len_d = s.dat_w[LEN_W-1:0];
        default: ;
      endcase
    end
    if (wr_ctrl) begin
      ie_d = s.dat_w[CTRL_IE];
      if (s.dat_w[CTRL_DONE]) done_d = 1'b0;
      if (s.dat_w[CTRL_ERR])  err_d  = 1'b0;
    end
    // a zero-length start completes immediately
    if (start) begin
      done_d = (len_q == '0);
      err_d  = 1'b0;
    end
    if (done_set_i) done_d = 1'b1;
    if (err_set_i)  err_d  = 1'b1;
    if (req && !s.we) begin
      case (a)
        REG_SRC: rdat_d = 32'(src_q);
        REG_DST: rdat_d = 32'(dst_q);
        REG_LEN: rdat_d = 32'(len_q);
        default: rdat_d = {27'd0, err_q, ie_q,
                           done_q, busy_i, 1'b0};
      endcase
    end
    irq_d   = done_d & ie_d;
    start_o = start & (len_q != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      rdat_q <= rdat_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      ie_q   <= ie_d;
      done_q <= done_d;
      err_q  <= err_d;
      irq_q  <= irq_d;
    end
  end

  assign s.ack   = ack_q;
  assign s.dat_r = rdat_q;
  assign s.err   = 1'b0;
  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign len_o   = len_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone word-copy engine: one read then one write per
// word, dropping cyc between transfers for re-arbitration.
module wb_dma_copy
  import wb_dma_copy_pkg::*;
#(
  parameter int AW    = 32,
  parameter int LEN_W = 16
) (
  input  logic          clk,
  input  logic          rstn,
  wb_dma_copy_if.slave  s,
  wb_dma_copy_if.master m,
  output logic          irq_o
);

  state_e           state_q, state_d;
  logic [AW-1:0]    rsrc_q, rsrc_d;
  logic [AW-1:0]    rdst_q, rdst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      buf_q, buf_d;
  logic             start, done_set, err_set, busy;
  logic [AW-1:0]    src, dst;
  logic [LEN_W-1:0] len;

  assign busy = (state_q != IDLE);

  wb_dma_regs #(.AW(AW), .LEN_W(LEN_W)) u_regs (
    .clk        (clk),
    .rstn       (rstn),
    .s          (s),
    .busy_i     (busy),
    .done_set_i (done_set),
    .err_set_i  (err_set),
    .start_o    (start),
    .src_o      (src),
    .dst_o      (dst),
    .len_o      (len),
    .irq_o      (irq_o)
  );

  always_comb begin
    state_d  = state_q;
    rsrc_d   = rsrc_q;
    rdst_d   = rdst_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    m.cyc    = 1'b0;
    m.stb    = 1'b0;
    m.we     = 1'b0;
    m.sel    = 4'h0;
    m.adr    = '0;
    m.dat_w  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rsrc_d  = src;
          rdst_d  = dst;
          rem_d   = len;
          state_d = RD;
        end
      end
      RD: begin
        m.cyc = 1'b1;
        m.stb = 1'b1;
        m.sel = 4'hF;
        m.adr = rsrc_q;
        if (m.err) begin
          done_set = 1'b1;
          err_set  = 1'b1;
          state_d  = IDLE;
        end else if (m.ack) begin
          buf_d   = m.dat_r;
          rsrc_d  = rsrc_q + AW'(4);
          state_d = GAP_W;
        end
      end
      GAP_W: state_d = WR;
      WR: begin
        m.cyc   = 1'b1;
        m.stb   = 1'b1;
        m.we    = 1'b1;
        m.sel   = 4'hF;
        m.adr   = rdst_q;
        m.dat_w = buf_q;
        if (m.err) begin
          done_set = 1'b1;
          err_set  = 1'b1;
          state_d  = IDLE;
        end else if (m.ack) begin
          rdst_d  = rdst_q + AW'(4);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? FIN : GAP_R;
        end
      end
      GAP_R: state_d = RD;
      FIN: begin
        done_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rsrc_q  <= '0;
      rdst_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      rsrc_q  <= rsrc_d;
      rdst_q  <= rdst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Bench for wb_dma_copy: register programming, a Wishbone
// slave model with a transfer scoreboard, error and reset.
module tb_wb_dma_copy;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic irq;

  wb_dma_copy_if #(.AW(32)) s_if ();
  wb_dma_copy_if #(.AW(32)) m_if ();

  wb_dma_copy dut (
    .clk   (clk),
    .rstn  (rstn),
    .s     (s_if),
    .m     (m_if),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xact_t;

  xact_t       exp_q[$];
  xact_t       x;
  int          n_checks = 0;
  int          n_errors = 0;
  int          waits = 0;
  int          err_rd = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          wcnt = 0;
  bit          cyc_seen = 0;
  logic [31:0] hold_adr, hold_dat;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory-less slave: read data is a function of address.
  always @(negedge clk) begin
    if (!rstn) begin
      m_if.ack   = 1'b0;
      m_if.err   = 1'b0;
      m_if.dat_r = '0;
      wcnt       = 0;
    end else begin
      if (m_if.cyc) cyc_seen = 1;
      if (m_if.ack || m_if.err) begin
        m_if.ack = 1'b0;
        m_if.err = 1'b0;
        wcnt     = 0;
        chk("gap_cyc", 32'(m_if.cyc), 32'd0);
      end else if (m_if.cyc && m_if.stb) begin
        if (wcnt == 0) begin
          hold_adr = m_if.adr;
          hold_dat = m_if.dat_w;
        end else begin
          chk("hold_adr", m_if.adr, hold_adr);
          chk("hold_dat", m_if.dat_w, hold_dat);
        end
        if (wcnt < waits) begin
          wcnt++;
        end else begin
          if (exp_q.size() == 0) begin
            chk("extra_xact", 32'd1, 32'd0);
          end else begin
            x = exp_q.pop_front();
            chk("xact_we", 32'(m_if.we), 32'(x.we));
            chk("xact_adr", m_if.adr, x.adr);
            if (x.we) chk("xact_dat", m_if.dat_w, x.dat);
          end
          if (!m_if.we) begin
            rd_cnt++;
            m_if.dat_r = pat(m_if.adr);
            if (rd_cnt == err_rd) m_if.err = 1'b1;
            else m_if.ack = 1'b1;
          end else begin
            wr_cnt++;
            m_if.ack = 1'b1;
          end
        end
      end
    end
  end

  task automatic xfer(input logic we, input logic [1:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd);
    @(posedge clk);
    #1;
    s_if.cyc   = 1'b1;
    s_if.stb   = 1'b1;
    s_if.we    = we;
    s_if.sel   = 4'hF;
    s_if.adr   = {28'h0, a, 2'b00};
    s_if.dat_w = wd;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (s_if.ack) break;
    end
    if (!s_if.ack) chk("s_ack_timeout", 32'd0, 32'd1);
    rd       = s_if.dat_r;
    s_if.cyc = 1'b0;
    s_if.stb = 1'b0;
    s_if.we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    xfer(1'b0, a, 32'd0, d);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq_timeout", 32'(irq), 32'd1);
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    int k;
    v = 32'h2;
    for (k = 0; k < 100 && v[1]; k++) rd(2'd3, v);
    chk("idle_timeout", 32'(v[1]), 32'd0);
  endtask

  task automatic push_copy(input logic [31:0] s,
                           input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, s + 32'(4 * i), 32'd0});
      exp_q.push_back('{1'b1, d + 32'(4 * i),
                        pat(s + 32'(4 * i))});
    end
  endtask

  task automatic chk_idle_outs(string tag);
    chk({tag, "_mctl"}, {27'd0, m_if.cyc, m_if.stb, m_if.we,
        m_if.sel == 4'h0, 1'b0}, 32'h2);
    chk({tag, "_madr"}, m_if.adr, 32'd0);
    chk({tag, "_mdat"}, m_if.dat_w, 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_sack"}, {s_if.ack, s_if.err} == 2'b00, 32'd1);
    chk({tag, "_sdat"}, s_if.dat_r, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int n, w0;
    s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
    s_if.sel = 4'h0; s_if.adr = '0; s_if.dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("rst");
    rstn = 1'b1;
    rd(2'd3, v); chk("rst_ctrl", v, 32'd0);
    rd(2'd0, v); chk("rst_src", v, 32'd0);

    // three zero-wait words
    wr(2'd0, 32'h100); wr(2'd1, 32'h200); wr(2'd2, 32'd3);
    push_copy(32'h100, 32'h200, 3);
    wr(2'd3, 32'h9);
    wait_irq(n);
    chk("t1_latency", 32'(n), 32'd12);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    rd(2'd3, v); chk("t1_ctrl", v, 32'hC);
    rd(2'd0, v); chk("t1_src", v, 32'h100);
    wr(2'd3, 32'hC);
    chk("t1_irq_clr", 32'(irq), 32'd0);

    // zero length: done at once, no bus activity
    cyc_seen = 0;
    wr(2'd2, 32'd0); wr(2'd3, 32'h1);
    rd(2'd3, v); chk("t2_ctrl", v, 32'h4);
    repeat (5) @(posedge clk);
    chk("t2_no_cyc", 32'(cyc_seen), 32'd0);
    wr(2'd3, 32'h4);

    // wait states
    waits = 3;
    wr(2'd0, 32'h1000); wr(2'd1, 32'h2000); wr(2'd2, 32'd2);
    push_copy(32'h1000, 32'h2000, 2);
    wr(2'd3, 32'h9);
    wait_irq(n);
    chk("t3_latency", 32'(n), 32'd20);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    wr(2'd3, 32'hC);

    // writes while busy are dropped
    wr(2'd0, 32'h300); wr(2'd1, 32'h400); wr(2'd2, 32'd2);
    push_copy(32'h300, 32'h400, 2);
    wr(2'd3, 32'h9);
    wr(2'd2, 32'd5);
    wr(2'd0, 32'hDEAD0000);
    wr(2'd3, 32'h9);
    wait_irq(n);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    rd(2'd2, v); chk("t4_len", v, 32'd2);
    rd(2'd0, v); chk("t4_src", v, 32'h300);
    wr(2'd3, 32'hC);
    chk("t4_irq_clr", 32'(irq), 32'd0);
    rd(2'd3, v); chk("t4_ctrl", v, 32'h8);
    waits = 0;

    // error on the second read
    wr(2'd0, 32'h500); wr(2'd1, 32'h600); wr(2'd2, 32'd4);
    exp_q.push_back('{1'b0, 32'h500, 32'd0});
    exp_q.push_back('{1'b1, 32'h600, pat(32'h500)});
    exp_q.push_back('{1'b0, 32'h504, 32'd0});
    err_rd = rd_cnt + 2;
    w0 = wr_cnt;
    wr(2'd3, 32'h1);
    wait_idle();
    rd(2'd3, v); chk("t5_ctrl", v, 32'h14);
    rd(2'd2, v); chk("t5_len", v, 32'd4);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    err_rd = 0;
    wr(2'd3, 32'h14);
    rd(2'd3, v); chk("t5_ctrl_clr", v, 32'h0);

    // address wrap at the top of the space
    wr(2'd0, 32'hFFFF_FFF8); wr(2'd1, 32'hFFFF_FFFC);
    wr(2'd2, 32'd2);
    push_copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 2);
    wr(2'd3, 32'h9);
    wait_irq(n);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    wr(2'd3, 32'hC);

    // reset during a write phase
    wr(2'd0, 32'h700); wr(2'd1, 32'h800); wr(2'd2, 32'd2);
    exp_q.push_back('{1'b0, 32'h700, 32'd0});
    wr(2'd3, 32'h9);
    n = 0;
    while (!(m_if.cyc && m_if.we) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t7_reach_wr", 32'(m_if.cyc && m_if.we), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t7_cyc_drop", {m_if.cyc, m_if.stb} == 2'b00, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outs("t7");
    chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);
    rd(2'd3, v); chk("t7_ctrl", v, 32'd0);
    rd(2'd0, v); chk("t7_src", v, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_dma_copy.md
Name: wb_dma_copy

Overview:
- Wishbone word-copy engine that acts as a bus master on a free master slot of wb_conmax_top (m2).
- The CPU programs it through a Wishbone slave register port: source address, destination address and length.
- Once started, it reads each word from the source and writes it to the destination, one word at a time, dropping cyc between transfers so the interconnect can re-arbitrate.
- It raises a level interrupt on completion, intended for a spare int_i bit.

Parameters:
- AW, 32, address width of both Wishbone ports.
- LEN_W, 16, width of the word-count register.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- s_cyc_i  in  1  slave port cycle
- s_stb_i  in  1  slave port strobe
- s_we_i  in  1  slave port write enable
- s_adr_i  in  AW  slave port address; only [3:2] decoded
- s_dat_i  in  32  slave port write data
- s_sel_i  in  4  slave port byte select; ignored, all writes are full-word
- s_dat_o  out  32  slave port read data
- s_ack_o  out  1  slave port acknowledge
- m_cyc_o  out  1  master port cycle
- m_stb_o  out  1  master port strobe
- m_we_o  out  1  master port write enable
- m_sel_o  out  4  master port byte select
- m_adr_o  out  AW  master port address
- m_dat_o  out  32  master port write data
- m_dat_i  in  32  master port read data
- m_ack_i  in  1  master port acknowledge
- m_err_i  in  1  master port error
- irq_o  out  1  completion interrupt

Behaviour:
- Reset: every output is 0; all registers and the FSM clear; state = IDLE.
- Register map (word offset s_adr_i[3:2]):
  - 0 SRC, R/W
  - 1 DST, R/W
  - 2 LEN, R/W, LEN_W bits, zero-extended on read
  - 3 CTRL:
    - bit0 START: W1 starts a copy; reads 0
    - bit1 BUSY: RO
    - bit2 DONE: W1C
    - bit3 IE: R/W
    - bit4 ERR: W1C
- Slave handshake:
  - s_ack_o is asserted the cycle after s_cyc_i&s_stb_i&!s_ack_o, for exactly one cycle.
  - The register write, or the s_dat_o capture, happens on that same edge.
  - Back-to-back strobes therefore complete every second cycle.
- Writes to SRC, DST or LEN while BUSY are ignored; they are still acked.
- START while BUSY is ignored.
- START with LEN=0: DONE is set the next cycle; no bus traffic is generated.
- START with LEN>0:
  - Copies SRC, DST and LEN into working counters rsrc, rdst and rem.
  - Sets BUSY and clears DONE and ERR.
  - Enters RD.
- Master FSM:
  - IDLE: all m_* outputs are 0.
  - RD:
    - Drives m_cyc_o=m_stb_o=1, m_we_o=0, m_sel_o=4'hF, m_adr_o=rsrc.
    - On m_ack_i: latch m_dat_i into buf, rsrc+=4, go to GAP_W.
  - GAP_W: cyc=stb=0 for one cycle, then WR.
  - WR:
    - Drives cyc=stb=we=1, sel=4'hF, m_adr_o=rdst, m_dat_o=buf.
    - On m_ack_i: rdst+=4, rem-=1.
    - If the new rem==0, go to FIN; otherwise go to GAP_R.
  - GAP_R: cyc=stb=0 for one cycle, then RD.
  - FIN: clear BUSY, set DONE, go to IDLE.
- Error handling: m_err_i in RD or WR ends the bus cycle, sets ERR and DONE, clears BUSY, and returns to IDLE. rem holds the unfinished count.
- Latency: minimum per word is 4 cycles with zero-wait-state slaves (RD, GAP_W, WR, GAP_R); ack wait states add directly.
- Address increments wrap modulo 2^AW.
- m_adr_o, m_we_o and m_dat_o stay stable while stb is high until ack or err.
- irq_o = DONE & IE, registered. It stays high until DONE is cleared by software.
- Simultaneous events:
  - W1C of DONE on the same edge FIN sets it: set wins.
  - START and a W1C of DONE in the same write: START wins, DONE ends up 0.
- Reset mid-transfer drops cyc and stb asynchronously; no partial state is retained.

Decomposition:
- Shared package/defines header holds:
  - register offsets (REG_SRC=2'd0, REG_DST=2'd1, REG_LEN=2'd2, REG_CTRL=2'd3)
  - CTRL bit indices
  - FSM state encoding (IDLE, RD, GAP_W, WR, GAP_R, FIN)
- One natural sub-module: wb_dma_regs (slave decode, ack generation, register file, W1C logic), exporting start pulse, SRC/DST/LEN values and the DONE/ERR set inputs.
- The master FSM stays in the top.

Test Plan:
- Program SRC=0x0000_0100, DST=0x0000_0200, LEN=3, CTRL=0x9 (START+IE); zero-wait slave model -> 3 reads at 0x100/0x104/0x108 and 3 writes at 0x200/0x204/0x208 with matching data; cyc low one cycle between each; BUSY cleared; irq_o=1 about 12 cycles after the start ack.
- LEN=0, CTRL=0x1 -> no m_cyc_o ever asserts; CTRL reads 0x4 two cycles later.
- Slave inserts 3 wait states per ack, LEN=2 -> 2 words copied; m_adr_o and m_dat_o held stable during waits; total 8+12 cycles.
- m_err_i on the second read of LEN=4 -> CTRL reads ERR|DONE (0x14); LEN register unchanged; exactly 1 write performed.
- Write LEN=5 and START while BUSY -> both ignored, the original copy completes; then write CTRL=0x4 -> DONE and irq_o clear.
- Deassert rstn during a WR phase -> m_cyc_o=0 immediately; every output 0 after release; CTRL reads 0.
